gy25_cmd_tx: RTL
================

# gy25_cmd_tx

UART command transmitter for the GY-25 tilt/heading module, the host-to-sensor counterpart of the GY-25 receive path. It accepts a 2-bit command request, serialises the two-byte GY-25 command frame (0xA5, then the command byte) as 8N1 at a fixed baud, and drives the sensor's RX pin. It runs in the 50 MHz PLL domain alongside the receiver and the angle extractor.

## Interface
Parameters:
- CLK_FREQ, 50_000_000, input clock frequency in Hz
- BAUD, 115200, serial bit rate; BIT_CYCLES = (CLK_FREQ + BAUD/2) / BAUD, which is 434 at the defaults

Ports:
- clk  input  1  system clock, 50 MHz
- rst_n  input  1  synchronous reset, active-high (1 = reset)
- cmd_valid  input  1  command request strobe
- cmd_code  input  2  00 = query (0x51), 01 = auto-output (0x52), 10 = tilt calibrate (0x54), 11 = heading zero (0x55)
- cmd_ready  output  1  high when a new command can be accepted
- tx  output  1  serial line to GY-25 RX; idles high
- busy  output  1  high while a frame is on the line
- done  output  1  one-cycle pulse when a frame completes

## Operation
- Reset values: tx=1, cmd_ready=1, busy=0, done=0, byte index=0, bit counter=0, baud counter=0.
- Accept a command when cmd_valid && cmd_ready. Latch the mapped command byte on acceptance; cmd_code has no further effect after that cycle.
- Frame is byte 0 = 0xA5, then byte 1 = latched command byte.
- Each byte is one start bit (0), eight data bits sent LSB first, and one stop bit (1). No gap between byte 0's stop bit and byte 1's start bit.
- Top FSM states and transitions:
  - IDLE: on accept, go to SEND.
  - SEND: when the byte-serialiser reports done with index=0, set index=1 and relaunch.
  - SEND: when the byte-serialiser reports done with index=1, go to IDLE and pulse done.
- Byte-serialiser FSM: IDLE → START → DATA (8 bits) → STOP → IDLE.
  - Baud counter counts 0..BIT_CYCLES-1 and wraps.
  - Each bit is held for exactly BIT_CYCLES clocks.
- cmd_ready = !busy. There is no queue: cmd_valid while busy is ignored and dropped.
- Reset mid-frame aborts immediately. tx is high in the cycle after the reset edge, and all state returns to reset values. The truncated frame is not resumed.
- Counters use $clog2(BIT_CYCLES) bits. Bit index is 3 bits and the byte index is 1 bit. Counters never exceed their terminal value.

## Timing
- Acceptance in cycle N: tx falls in cycle N+1, and busy and !cmd_ready are visible from cycle N+1.
- Line time per frame: exactly 20×BIT_CYCLES clocks, from tx falling to the end of the second stop bit (8680 clocks at the defaults).
- done is high for one cycle, in the first cycle after the final stop bit completes. In that cycle busy=0 and cmd_ready=1.
- Back-to-back: a command accepted in the done cycle starts its start bit on the next clock. The minimum inter-frame idle time on tx is therefore 1 clock beyond the stop bit.
- No combinational path from any input to tx.

## Structure
- Shared package gy25_pkg holds:
  - GY25_HDR = 8'hA5
  - command byte constants CMD_QUERY / CMD_AUTO / CMD_CAL_TILT / CMD_ZERO_HEAD
  - the 2-bit cmd_code enum
  - the BIT_CYCLES computation function
- The receive side also uses this package.
- One sub-module: uart_byte_tx (8N1 byte serialiser, parameterised by BIT_CYCLES, with start/done handshake). The top holds only the command mapping and the 2-byte sequencer.

## Test plan
- Reset: hold rst_n=1 for 5 cycles → tx=1, cmd_ready=1, busy=0, done=0 throughout.
- Query: cmd_code=00 pulsed once → tx carries 0xA5 then 0x51 (LSB first, 434 clocks per bit). done pulses exactly 8681 clocks after acceptance; a UART monitor decodes A5 51.
- All codes back-to-back: cmd_valid held high, cycling codes 01, 10, 11 on each done → decoded bytes A5 52 A5 54 A5 55. Each new start bit begins 1 clock after done.
- Busy drop: pulse cmd_valid with code 11 at clock 3000 of a query frame → only A5 51 is transmitted, and no second frame follows.
- Reset mid-frame: assert rst_n during the data bits of byte 1 → tx=1 on the next cycle, no done pulse, and a fresh query afterwards transmits correctly.
- BAUD=9600 build: query → each bit is 5208 clocks, and the frame is 104160 clocks.

Source files
------------

// File: rtl/gy25_pkg.sv
// Shared GY-25 constants, command encoding and baud helper (TX and RX paths).
package gy25_pkg;

  localparam logic [7:0] GY25_HDR      = 8'hA5;
  localparam logic [7:0] CMD_QUERY     = 8'h51;
  localparam logic [7:0] CMD_AUTO      = 8'h52;
  localparam logic [7:0] CMD_CAL_TILT  = 8'h54;
  localparam logic [7:0] CMD_ZERO_HEAD = 8'h55;

  typedef enum logic [1:0] {
    CODE_QUERY     = 2'b00,
    CODE_AUTO      = 2'b01,
    CODE_CAL_TILT  = 2'b10,
    CODE_ZERO_HEAD = 2'b11
  } cmd_code_e;

  // Clocks per serial bit, rounded to nearest.
  function automatic int unsigned bit_cycles(input int unsigned clk_freq,
                                             input int unsigned baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

  // Map a 2-bit request code onto the GY-25 command byte.
  function automatic logic [7:0] cmd_byte(input cmd_code_e code);
    logic [7:0] b;
    case (code)
      CODE_QUERY:     b = CMD_QUERY;
      CODE_AUTO:      b = CMD_AUTO;
      CODE_CAL_TILT:  b = CMD_CAL_TILT;
      CODE_ZERO_HEAD: b = CMD_ZERO_HEAD;
      default:        b = CMD_QUERY;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/gy25_cmd_tx_if.sv
// Command request / serial line bundle between the host logic and gy25_cmd_tx.
interface gy25_cmd_tx_if;
  logic       cmd_valid;
  logic [1:0] cmd_code;
  logic       cmd_ready;
  logic       tx;
  logic       busy;
  logic       done;

  modport master (output cmd_valid, cmd_code,
                  input  cmd_ready, tx, busy, done);
  modport slave  (input  cmd_valid, cmd_code,
                  output cmd_ready, tx, busy, done);
endinterface

// File: rtl/uart_byte_tx.sv
// 8N1 byte serialiser; a start in the final stop-bit cycle chains the next byte gap-free.
module uart_byte_tx #(
  parameter int unsigned BIT_CYCLES = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_start,
  input  logic [7:0] i_data,
  output logic       o_tx,
  output logic       o_done_c
);

  localparam int unsigned CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]    r_state, w_state_nxt;
  logic [CW-1:0] r_baud,  w_baud_nxt;
  logic [2:0]    r_bit,   w_bit_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic          r_tx,    w_tx_nxt;
  logic          w_bit_end;

  assign w_bit_end = (r_baud == CW'(BIT_CYCLES - 1));
  assign o_done_c  = (r_state == S_STOP) && w_bit_end;
  assign o_tx      = r_tx;

  // State register; reset forces the line idle at once.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
    end
  end

  // Bit timing and next-state / next-line-level logic.
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_tx_nxt    = r_tx;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt = S_START;
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
          w_shift_nxt = i_data;
          w_tx_nxt    = 1'b0;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_state_nxt = S_DATA;
          w_baud_nxt  = '0;
          w_tx_nxt    = r_shift[0];
        end else begin
          w_baud_nxt = r_baud + CW'(1);
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_baud_nxt = '0;
          if (r_bit == 3'd7) begin
            w_state_nxt = S_STOP;
            w_bit_nxt   = '0;
            w_tx_nxt    = 1'b1;
          end else begin
            w_bit_nxt   = r_bit + 3'd1;
            w_shift_nxt = {1'b0, r_shift[7:1]};
            w_tx_nxt    = r_shift[1];
          end
        end else begin
          w_baud_nxt = r_baud + CW'(1);
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          w_baud_nxt = '0;
          if (i_start) begin
            w_state_nxt = S_START;
            w_bit_nxt   = '0;
            w_shift_nxt = i_data;
            w_tx_nxt    = 1'b0;
          end else begin
            w_state_nxt = S_IDLE;
            w_tx_nxt    = 1'b1;
          end
        end else begin
          w_baud_nxt = r_baud + CW'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_tx_nxt    = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/gy25_cmd_tx.sv
// GY-25 command transmitter: maps the request code and sequences header + command bytes.
module gy25_cmd_tx
  import gy25_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic          clk,
  input  logic          rst_n,
  gy25_cmd_tx_if.slave  bus
);

  localparam int unsigned BIT_CYCLES = bit_cycles(CLK_FREQ, BAUD);

  localparam logic [0:0] T_IDLE = 1'b0;
  localparam logic [0:0] T_SEND = 1'b1;

  logic [0:0] r_state, w_state_nxt;
  logic       r_idx,   w_idx_nxt;
  logic [7:0] r_cmd,   w_cmd_nxt;
  logic       r_busy,  w_busy_nxt;
  logic       r_ready, w_ready_nxt;
  logic       r_done,  w_done_nxt;
  logic       w_accept;
  logic       w_start;
  logic       w_byte_done;
  logic [7:0] w_data;
  logic       w_tx;

  assign w_accept = bus.cmd_valid && r_ready;
  // Header goes out on launch from idle; the relaunch always carries the command.
  assign w_data   = (r_state == T_IDLE) ? GY25_HDR : r_cmd;

  assign bus.tx        = w_tx;
  assign bus.busy      = r_busy;
  assign bus.cmd_ready = r_ready;
  assign bus.done      = r_done;

  uart_byte_tx #(.BIT_CYCLES(BIT_CYCLES)) u_byte_tx (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_start  (w_start),
    .i_data   (w_data),
    .o_tx     (w_tx),
    .o_done_c (w_byte_done)
  );

  // Sequencer state and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_state <= T_IDLE;
      r_idx   <= 1'b0;
      r_cmd   <= '0;
      r_busy  <= 1'b0;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_cmd   <= w_cmd_nxt;
      r_busy  <= w_busy_nxt;
      r_ready <= w_ready_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Two-byte frame sequencing: accept, relaunch after header, finish after command.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cmd_nxt   = r_cmd;
    w_busy_nxt  = r_busy;
    w_ready_nxt = r_ready;
    w_done_nxt  = 1'b0;
    w_start     = 1'b0;
    case (r_state)
      T_IDLE: begin
        if (w_accept) begin
          w_state_nxt = T_SEND;
          w_idx_nxt   = 1'b0;
          w_cmd_nxt   = cmd_byte(cmd_code_e'(bus.cmd_code));
          w_busy_nxt  = 1'b1;
          w_ready_nxt = 1'b0;
          w_start     = 1'b1;
        end
      end
      T_SEND: begin
        if (w_byte_done) begin
          if (r_idx == 1'b0) begin
            w_idx_nxt = 1'b1;
            w_start   = 1'b1;
          end else begin
            w_state_nxt = T_IDLE;
            w_idx_nxt   = 1'b0;
            w_busy_nxt  = 1'b0;
            w_ready_nxt = 1'b1;
            w_done_nxt  = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = T_IDLE;
      end
    endcase
  end

endmodule
